// File: rtl/line_arbiter.sv
// Shared cache-line arbiter: N caches request line reads/writes, one
// transaction at a time is forwarded to the downstream line adaptor.
module line_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int RR_MODE    = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             req_read_i,
   input  logic [NUM_PORTS-1:0]             req_write_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata_i,
   output logic [LINE_WIDTH-1:0]            req_rdata_o,
   output logic [NUM_PORTS-1:0]             req_resp_o,
   output logic                             mem_read_o,
   output logic                             mem_write_o,
   output logic [ADDR_WIDTH-1:0]            mem_addr_o,
   output logic [LINE_WIDTH-1:0]            mem_wdata_o,
   input  logic [LINE_WIDTH-1:0]            mem_rdata_i,
   input  logic                             mem_resp_i,
   output logic [$clog2(NUM_PORTS)-1:0]     grant_o,
   output logic                             busy_o
);

   localparam int GW = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [GW-1:0]         grant;
   logic [GW-1:0]         last;
   logic [ADDR_WIDTH-1:0] addr;
   logic [LINE_WIDTH-1:0] wdata;
   logic [LINE_WIDTH-1:0] rdata;
   logic                  op_write;

   logic [NUM_PORTS-1:0]  req;
   logic                  found;
   logic [GW-1:0]         winner;
   logic [GW-1:0]         idx;

   // Search order starts just after the last winner in RR mode,
   // at port 0 in fixed mode.
   always_comb begin
      req    = req_read_i | req_write_i;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (RR_MODE != 0)
            idx = GW'((int'(last) + 1 + i) % NUM_PORTS);
         else
            idx = GW'(i);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (found) state_nxt = ISSUE;
         ISSUE:   if (mem_resp_i) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         last     <= GW'(NUM_PORTS - 1);
         addr     <= '0;
         wdata    <= '0;
         rdata    <= '0;
         op_write <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && found) begin
            grant    <= winner;
            last     <= winner;
            addr     <= req_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
            wdata    <= req_wdata_i[winner*LINE_WIDTH +: LINE_WIDTH];
            // a simultaneous read on the same port is dropped
            op_write <= req_write_i[winner];
         end
         if (state == ISSUE && mem_resp_i)
            rdata <= mem_rdata_i;
      end
   end

   always_comb begin
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      req_resp_o  = '0;
      if (state == ISSUE) begin
         mem_read_o  = !op_write;
         mem_write_o = op_write;
         mem_addr_o  = addr;
         mem_wdata_o = wdata;
      end
      if (state == RESP)
         req_resp_o[grant] = 1'b1;
   end

   assign req_rdata_o = rdata;
   assign grant_o     = grant;
   assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_line_arbiter.sv
// Bench for line_arbiter: 2-port RR and fixed instances share stimulus,
// a 4-port RR instance checks wrap-around.
module tb_line_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]      rd, wr;
   logic [2*AW-1:0] addr;
   logic [2*LW-1:0] wdata;
   logic [LW-1:0]   mrdata;
   logic            mresp;

   logic [LW-1:0] rdata_a, mwd_a, rdata_b, mwd_b;
   logic [1:0]    resp_a, resp_b;
   logic          mrd_a, mwr_a, busy_a, mrd_b, mwr_b, busy_b;
   logic [AW-1:0] maddr_a, maddr_b;
   logic [0:0]    gnt_a, gnt_b;

   logic [3:0]      rd4, wr4;
   logic [4*AW-1:0] addr4;
   logic [4*LW-1:0] wdata4;
   logic [LW-1:0]   mrdata4;
   logic            mresp4;
   logic [LW-1:0]   rdata_c, mwd_c;
   logic [3:0]      resp_c;
   logic            mrd_c, mwr_c, busy_c;
   logic [AW-1:0]   maddr_c;
   logic [1:0]      gnt_c;

   int n_cmp = 0;
   int n_err = 0;
   int last_a, last_c;

   line_arbiter #(.NUM_PORTS(2), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_MODE(1)) dut_a (
      .clk(clk), .rst(rst), .req_read_i(rd), .req_write_i(wr),
      .req_addr_i(addr), .req_wdata_i(wdata), .req_rdata_o(rdata_a),
      .req_resp_o(resp_a), .mem_read_o(mrd_a), .mem_write_o(mwr_a),
      .mem_addr_o(maddr_a), .mem_wdata_o(mwd_a), .mem_rdata_i(mrdata),
      .mem_resp_i(mresp), .grant_o(gnt_a), .busy_o(busy_a));

   line_arbiter #(.NUM_PORTS(2), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_MODE(0)) dut_b (
      .clk(clk), .rst(rst), .req_read_i(rd), .req_write_i(wr),
      .req_addr_i(addr), .req_wdata_i(wdata), .req_rdata_o(rdata_b),
      .req_resp_o(resp_b), .mem_read_o(mrd_b), .mem_write_o(mwr_b),
      .mem_addr_o(maddr_b), .mem_wdata_o(mwd_b), .mem_rdata_i(mrdata),
      .mem_resp_i(mresp), .grant_o(gnt_b), .busy_o(busy_b));

   line_arbiter #(.NUM_PORTS(4), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_MODE(1)) dut_c (
      .clk(clk), .rst(rst), .req_read_i(rd4), .req_write_i(wr4),
      .req_addr_i(addr4), .req_wdata_i(wdata4), .req_rdata_o(rdata_c),
      .req_resp_o(resp_c), .mem_read_o(mrd_c), .mem_write_o(mwr_c),
      .mem_addr_o(maddr_c), .mem_wdata_o(mwd_c), .mem_rdata_i(mrdata4),
      .mem_resp_i(mresp4), .grant_o(gnt_c), .busy_o(busy_c));

   task automatic chk(input string tag, input logic [LW-1:0] got,
                      input logic [LW-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference arbitration rule: first requester in search order.
   function automatic int pick(input logic [7:0] mask, input int n,
                               input int last, input bit rr);
      for (int k = 0; k < n; k++) begin
         int p;
         p = rr ? (last + 1 + k) % n : k;
         if (mask[p]) return p;
      end
      return -1;
   endfunction

   function automatic logic [LW-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   // One transaction on the 2-port pair, starting from IDLE.
   task automatic txn(input string tag, input int d, input logic [LW-1:0] line,
                      input bit drop, input bit rel, output int pa, output int pb);
      bit wa, wb;
      logic [AW-1:0] ea, eb;
      logic [LW-1:0] da, db;
      pa = pick({6'b0, rd | wr}, 2, last_a, 1'b1);
      pb = pick({6'b0, rd | wr}, 2, 0, 1'b0);
      if (pa < 0 || pb < 0) begin
         chk({tag, " no_request"}, LW'(0), LW'(1));
         return;
      end
      wa = wr[pa];
      wb = wr[pb];
      ea = addr[pa*AW +: AW];
      eb = addr[pb*AW +: AW];
      da = wdata[pa*LW +: LW];
      db = wdata[pb*LW +: LW];
      last_a = pa;
      @(posedge clk); #1;
      for (int c = 0; c < d; c++) begin
         chk({tag, " issue_a"}, LW'({mrd_a, mwr_a, maddr_a, resp_a, gnt_a, busy_a}),
             LW'({~wa, wa, ea, 2'b00, 1'(pa), 1'b1}));
         chk({tag, " issue_b"}, LW'({mrd_b, mwr_b, maddr_b, resp_b, gnt_b, busy_b}),
             LW'({~wb, wb, eb, 2'b00, 1'(pb), 1'b1}));
         if (wa) chk({tag, " wdata_a"}, mwd_a, da);
         if (wb) chk({tag, " wdata_b"}, mwd_b, db);
         if (drop && c == 0) begin
            rd[pa] = 1'b0;
            wr[pa] = 1'b0;
         end
         if (c == d - 1) begin
            mresp  = 1'b1;
            mrdata = line;
         end
         @(posedge clk); #1;
      end
      mresp  = 1'b0;
      mrdata = ~line;
      chk({tag, " resp_a"}, LW'({mrd_a, mwr_a, resp_a, gnt_a, busy_a}),
          LW'({2'b00, 2'(1 << pa), 1'(pa), 1'b1}));
      chk({tag, " resp_b"}, LW'({mrd_b, mwr_b, resp_b, gnt_b, busy_b}),
          LW'({2'b00, 2'(1 << pb), 1'(pb), 1'b1}));
      chk({tag, " rdata_a"}, rdata_a, line);
      chk({tag, " rdata_b"}, rdata_b, line);
      if (rel) begin
         rd[pa] = 1'b0;
         wr[pa] = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, " idle"}, LW'({resp_a, resp_b, busy_a, busy_b, mrd_a, mwr_a}), LW'(0));
   endtask

   // One read transaction on the 4-port instance, requests held.
   task automatic txn4(input string tag, input int d, output int p);
      logic [LW-1:0] line;
      line = rand_line();
      p = pick({4'b0, rd4 | wr4}, 4, last_c, 1'b1);
      last_c = p;
      @(posedge clk); #1;
      for (int c = 0; c < d; c++) begin
         chk({tag, " issue"}, LW'({mrd_c, mwr_c, maddr_c, resp_c, gnt_c, busy_c}),
             LW'({2'b10, addr4[p*AW +: AW], 4'b0000, 2'(p), 1'b1}));
         if (c == d - 1) begin
            mresp4  = 1'b1;
            mrdata4 = line;
         end
         @(posedge clk); #1;
      end
      mresp4 = 1'b0;
      chk({tag, " resp"}, LW'({mrd_c, resp_c, gnt_c, busy_c}),
          LW'({1'b0, 4'(1 << p), 2'(p), 1'b1}));
      chk({tag, " rdata"}, rdata_c, line);
      @(posedge clk); #1;
      chk({tag, " idle"}, LW'({resp_c, busy_c}), LW'(0));
   endtask

   initial begin
      int ga, gb;
      int exp_a[4];
      int exp4[7];
      rd = '0; wr = '0; addr = '0; wdata = '0; mrdata = '0; mresp = 1'b0;
      rd4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0; mrdata4 = '0; mresp4 = 1'b0;
      last_a = 1;
      last_c = 3;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a", LW'({mrd_a, mwr_a, maddr_a, resp_a, gnt_a, busy_a}), LW'(0));
      chk("rst_b", LW'({mrd_b, mwr_b, maddr_b, resp_b, gnt_b, busy_b}), LW'(0));
      chk("rst_c", LW'({mrd_c, mwr_c, maddr_c, resp_c, gnt_c, busy_c}), LW'(0));
      chk("rst_lines", mwd_a | rdata_a | mwd_c | rdata_c, LW'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // single read on port 1, memory answers in the 4th ISSUE cycle
      addr[AW +: AW] = 32'h0000_1000;
      rd = 2'b10;
      txn("single_rd", 4, {32{8'hA5}}, 1'b0, 1'b1, ga, gb);
      chk("single_rd grant", LW'(ga), LW'(1));

      // continuous contention
      addr = {32'h0000_0200, 32'h0000_0100};
      rd = 2'b11;
      exp_a = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) begin
         txn("contend", $urandom_range(1, 3), rand_line(), 1'b0, 1'b0, ga, gb);
         chk("contend rr_grant", LW'(ga), LW'(exp_a[i]));
         chk("contend fixed_grant", LW'(gb), LW'(0));
      end
      rd = 2'b00;

      // write
      addr[0 +: AW] = 32'h40;
      wdata[0 +: LW] = LW'(16'h1234);
      wr = 2'b01;
      txn("write", 2, rand_line(), 1'b0, 1'b1, ga, gb);

      // read and write together on the same port
      rd = 2'b01;
      wr = 2'b01;
      txn("rd_wr", 1, rand_line(), 1'b0, 1'b1, ga, gb);

      // requester drops during ISSUE
      rd = 2'b10;
      txn("drop", 3, rand_line(), 1'b1, 1'b1, ga, gb);

      // reset two cycles into ISSUE
      addr[0 +: AW] = 32'h80;
      rd = 2'b01;
      @(posedge clk); #1;
      chk("rst_mid issue", LW'(mrd_a), LW'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      rd = 2'b00;
      #1;
      chk("rst_mid async", LW'({mrd_a, mwr_a, resp_a, busy_a, mrd_b, resp_b, busy_b}), LW'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      last_a = 1;
      last_c = 3;
      mresp = 1'b1;
      mrdata = rand_line();
      @(posedge clk); #1;
      mresp = 1'b0;
      chk("late_resp", LW'({resp_a, busy_a, mrd_a, resp_b, busy_b}), LW'(0));
      @(posedge clk); #1;
      chk("late_resp2", LW'({resp_a, busy_a, resp_b, busy_b}), LW'(0));
      rd = 2'b11;
      txn("after_rst", 2, rand_line(), 1'b0, 1'b1, ga, gb);
      chk("after_rst grant", LW'(ga), LW'(0));
      rd = 2'b00;

      // randomized traffic
      for (int it = 0; it < 24; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (!(rd[p] | wr[p]) && $urandom_range(0, 1) == 1) begin
               rd[p] = 1'($urandom_range(0, 1));
               wr[p] = 1'($urandom_range(0, 1));
               addr[p*AW +: AW] = $urandom;
               wdata[p*LW +: LW] = rand_line();
            end
         end
         if ((rd | wr) == 2'b00) begin
            rd[$urandom_range(0, 1)] = 1'b1;
         end
         txn("random", $urandom_range(1, 4), rand_line(),
             $urandom_range(0, 3) == 0, 1'b1, ga, gb);
      end
      rd = 2'b00;
      wr = 2'b00;

      // 4-port round-robin, all requesting, then ports 0 and 3 only
      for (int p = 0; p < 4; p++) addr4[p*AW +: AW] = 32'h1000 * (p + 1);
      rd4 = 4'hF;
      exp4 = '{0, 1, 2, 3, 0, 3, 0};
      for (int i = 0; i < 7; i++) begin
         if (i == 5) rd4 = 4'b1001;
         txn4("rr4", $urandom_range(1, 3), ga);
         chk("rr4 grant", LW'(ga), LW'(exp4[i]));
      end
      rd4 = 4'h0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/line_arbiter.md
LINE_ARBITER -- requirements
Module: line_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting caches (legal range 2..8).
REQ-002 SHALL have parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, line address width.
REQ-004 SHALL have parameter RR_MODE, default 1; 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-005 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_read_i  in  NUM_PORTS  per-port line read request, held until that port's resp.
REQ-008 SHALL have port req_write_i  in  NUM_PORTS  per-port line write request, held until that port's resp.
REQ-009 SHALL have port req_addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port address; port p occupies slice p.
REQ-010 SHALL have port req_wdata_i  in  NUM_PORTS*LINE_WIDTH  per-port write line; port p occupies slice p.
REQ-011 SHALL have port req_rdata_o  out  LINE_WIDTH  read line, shared by all ports, valid only with a resp.
REQ-012 SHALL have port req_resp_o  out  NUM_PORTS  one-hot completion pulse to the served port.
REQ-013 SHALL have port mem_read_o  out  1  downstream line read (to cacheline adaptor).
REQ-014 SHALL have port mem_write_o  out  1  downstream line write.
REQ-015 SHALL have port mem_addr_o  out  ADDR_WIDTH  downstream address.
REQ-016 SHALL have port mem_wdata_o  out  LINE_WIDTH  downstream write line.
REQ-017 SHALL have port mem_rdata_i  in  LINE_WIDTH  downstream read line, valid with mem_resp_i.
REQ-018 SHALL have port mem_resp_i  in  1  downstream completion, one cycle.
REQ-019 SHALL have port grant_o  out  $clog2(NUM_PORTS)  index of port being served.
REQ-020 SHALL have port busy_o  out  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE, one transaction at a time.
REQ-022 IDLE: if any port requests, SHALL select a winner, register its index, address, wdata and op, and go to ISSUE next cycle; otherwise stay in IDLE.
REQ-023 Op select: write SHALL take precedence if a port asserts read and write together; that read is not served.
REQ-024 Fixed mode: the lowest-index requesting port SHALL win.
REQ-025 RR mode: search SHALL start at (last_grant+1) mod NUM_PORTS and wrap; last_grant updates only on a grant.
REQ-026 ISSUE: mem_read_o or mem_write_o SHALL be high, with mem_addr_o/mem_wdata_o from registers, stable until mem_resp_i.
REQ-027 ISSUE with mem_resp_i=1 SHALL register mem_rdata_i and go to RESP; mem_read_o/mem_write_o drop the following cycle.
REQ-028 RESP: req_resp_o[grant] SHALL be 1 for exactly one cycle, all other bits 0, req_rdata_o = registered line; then go to IDLE.
REQ-029 Latency: request at IDLE cycle t SHALL give mem op at t+1; mem_resp_i at cycle k SHALL give req_resp_o at k+1; minimum 3 cycles, request to resp.
REQ-030 A requester dropping its request during ISSUE SHALL NOT abort the transaction; its resp still pulses.
REQ-031 mem_resp_i outside ISSUE SHALL be ignored.
REQ-032 Requests arriving in ISSUE or RESP SHALL wait; arbitration occurs only in IDLE.
REQ-033 Two back-to-back transactions SHALL have at least one IDLE cycle between RESP and the next ISSUE.

Reset
REQ-034 rst high SHALL immediately force: state IDLE, all mem_* outputs 0, req_resp_o 0, req_rdata_o 0, grant_o 0, busy_o 0.
REQ-035 SHALL reset last_grant to NUM_PORTS-1, so port 0 wins the first RR arbitration.
REQ-036 Reset mid-transaction SHALL abandon it without a resp pulse; a late mem_resp_i after reset SHALL be ignored.

Verification
REQ-037 Single read: port1 read, addr 0x0000_1000; mem_resp_i after 4 cycles with line 0xA5..A5 -> mem_read_o 4 cycles, req_resp_o=2'b10 one cycle, req_rdata_o=0xA5..A5.
REQ-038 Contention, RR: ports 0 and 1 both read continuously for 4 transactions -> grants 0,1,0,1; fixed mode -> grants 0,0,0,0.
REQ-039 Write: port0 write, addr 0x40, wdata 0x1234 -> mem_write_o=1, mem_addr_o=0x40, mem_wdata_o=0x1234 until resp; req_resp_o=2'b01.
REQ-040 Read+write same port: both asserted -> only mem_write_o asserted, a single resp.
REQ-041 Reset mid-ISSUE: rst asserted 2 cycles into an ISSUE -> mem_read_o=0 same cycle, no resp; a mem_resp_i after reset is ignored; the next request is served normally.
REQ-042 NUM_PORTS=4, RR, all requesting -> grants 0,1,2,3,0, with wrap-around checked.
